// File: rtl/data_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | data_mem_arbiter: round-robin sharing of the data memory between the core  |
// | MemoryAccess stage and an external master.           Revision: 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_mem_arbiter #(
    parameter int XLEN   = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_req,
    input  logic [3:0]      core_we,
    input  logic [XLEN-1:0] core_addr,
    input  logic [XLEN-1:0] core_wdata,
    output logic [XLEN-1:0] core_rdata,
    output logic            core_done,
    output logic            core_stall,
    input  logic            ext_req,
    input  logic [3:0]      ext_we,
    input  logic [XLEN-1:0] ext_addr,
    input  logic [XLEN-1:0] ext_wdata,
    output logic            ext_ack,
    output logic [XLEN-1:0] ext_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_we,
    output logic            mem_re,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [2:0] LAT_C = 3'(RD_LAT);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              last_ext_q, last_ext_d;
    logic              owner_ext_q, owner_ext_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   core_rdata_q, core_rdata_d;
    logic [XLEN-1:0]   ext_rdata_q, ext_rdata_d;

    logic              grant_core, grant_ext;
    logic [3:0]        win_we;
    logic [XLEN-1:0]   win_addr, win_wdata;

    // No issue while reset is held, so a requester cannot leak a pulse through.
    always_comb begin
        grant_core = 1'b0;
        grant_ext  = 1'b0;
        if (rst_n && state_q == IDLE) begin
            if (core_req && ext_req) begin
                grant_core = last_ext_q;
                grant_ext  = ~last_ext_q;
            end else begin
                grant_core = core_req;
                grant_ext  = ext_req;
            end
        end
    end

    assign win_we    = grant_ext ? ext_we    : core_we;
    assign win_addr  = grant_ext ? ext_addr  : core_addr;
    assign win_wdata = grant_ext ? ext_wdata : core_wdata;

    always_comb begin
        state_d      = state_q;
        last_ext_d   = last_ext_q;
        owner_ext_d  = owner_ext_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_rdata_d = core_rdata_q;
        ext_rdata_d  = ext_rdata_q;
        mem_we       = 4'b0000;
        mem_re       = 1'b0;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
        core_done    = 1'b0;
        ext_ack      = 1'b0;
        core_rdata   = core_rdata_q;
        ext_rdata    = ext_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_core || grant_ext) begin
                    mem_addr  = win_addr;
                    mem_wdata = win_wdata;
                    addr_d    = win_addr;
                    wdata_d   = win_wdata;
                    if (win_we != 4'b0000) begin
                        mem_we     = win_we;
                        core_done  = grant_core;
                        ext_ack    = grant_ext;
                        last_ext_d = grant_ext;
                    end else begin
                        mem_re      = 1'b1;
                        owner_ext_d = grant_ext;
                        cnt_d       = 3'd1;
                        state_d     = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 3'd1;
                // Read data is passed straight through on the completion cycle.
                if (cnt_q == LAT_C) begin
                    if (owner_ext_q) begin
                        ext_ack     = 1'b1;
                        ext_rdata   = mem_rdata;
                        ext_rdata_d = mem_rdata;
                    end else begin
                        core_done    = 1'b1;
                        core_rdata   = mem_rdata;
                        core_rdata_d = mem_rdata;
                    end
                    last_ext_d = owner_ext_q;
                    cnt_d      = 3'd0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_stall = core_req & ~core_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_ext_q   <= 1'b1;
            owner_ext_q  <= 1'b0;
            cnt_q        <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_ext_q   <= last_ext_d;
            owner_ext_q  <= owner_ext_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rdata_q <= core_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

endmodule

`default_nettype wire
